data_sram_ctrl: RTL and testbench



---
 rtl/data_sram_ctrl_pkg.sv | 23 ++
 rtl/data_sram_ctrl_if.sv | 23 ++
 rtl/data_sram_ctrl.sv | 106 ++++++++++
 tb/tb_data_sram_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// Shared encodings and defaults for the MEM-stage data SRAM controller.
// Holds FSM states, default access length and the claimed address window.
package data_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        DSRAM_IDLE   = 2'd0,
        DSRAM_ACCESS = 2'd1,
        DSRAM_DONE   = 2'd2
    } dsram_state_t;

    localparam int          DSRAM_WAIT_CYCLES_DEF = 2;
    localparam int          DSRAM_CNT_W           = 4;
    localparam logic [31:0] DSRAM_BASE_ADDR       = 32'h8000_0000;
    localparam logic [31:0] DSRAM_SIZE_BYTES      = 32'h0040_0000;

    // Subtract-then-compare so a window ending at 2^32 needs no 33-bit bound.
    function automatic logic dsram_in_window(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// MEM-stage side of the data-memory request: request fields, flush, and the
// stall / read data / address-error responses.
interface data_sram_ctrl_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        flush_i;
    logic [31:0] mem_data_o;
    logic        stall_o;
    logic        mem_err_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, flush_i,
        input  mem_data_o, stall_o, mem_err_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, flush_i,
        output mem_data_o, stall_o, mem_err_o
    );
endinterface

// File: rtl/data_sram_ctrl.sv
// Data SRAM controller: runs one async-SRAM read/write per MEM-stage request (DSRAM_ADDR_CHECK_EN adds window check).
// Latency: WAIT_CYCLES+1 cycles per access (IDLE + WAIT_CYCLES in ACCESS), then a DONE cycle.
// Backpressure: stall_o is combinational from the request and stays high until the DONE cycle.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 20,
    parameter int          WAIT_CYCLES = DSRAM_WAIT_CYCLES_DEF,
    parameter logic [31:0] BASE_ADDR   = DSRAM_BASE_ADDR,
    parameter logic [31:0] SIZE_BYTES  = DSRAM_SIZE_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    data_sram_ctrl_if.slave   mem,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    dsram_state_t           state_q, state_d;
    logic [DSRAM_CNT_W-1:0] cnt_q;
    logic                   we_q;
    logic [31:0]            rdata_q;

    logic req, addr_err, accept, last, abort;

    assign req = mem.mem_ce_i & (|mem.mem_sel_i);

`ifdef DSRAM_ADDR_CHECK_EN
    assign addr_err = (state_q == DSRAM_IDLE) & req &
                      ~dsram_in_window(mem.mem_addr_i, BASE_ADDR, SIZE_BYTES);
    logic unused_addr;
    assign unused_addr = ^mem.mem_addr_i[1:0];
`else
    assign addr_err = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{mem.mem_addr_i[31:ADDR_W+2], mem.mem_addr_i[1:0],
                           BASE_ADDR, SIZE_BYTES};
`endif

    assign accept = (state_q == DSRAM_IDLE) & req & ~addr_err & ~mem.flush_i;
    assign last   = (state_q == DSRAM_ACCESS) & (cnt_q == '0);
    // Only reads may be abandoned on flush; a write already on the pins must finish.
    assign abort  = (state_q == DSRAM_ACCESS) & ~we_q & mem.flush_i;

    assign mem.stall_o    = rst_n & req & ~addr_err & (state_q != DSRAM_DONE);
    assign mem.mem_err_o  = rst_n & addr_err;
    assign mem.mem_data_o = rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DSRAM_IDLE:   if (accept) state_d = DSRAM_ACCESS;
            DSRAM_ACCESS: begin
                if (abort)     state_d = DSRAM_IDLE;
                else if (last) state_d = DSRAM_DONE;
            end
            DSRAM_DONE:   state_d = DSRAM_IDLE;
            default:      state_d = DSRAM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= DSRAM_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
        end else if (accept) begin
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= mem.mem_we_i;
            sram_we_n  <= ~mem.mem_we_i;
            sram_be_n  <= ~mem.mem_sel_i;
            sram_addr  <= mem.mem_addr_i[ADDR_W+1:2];
            sram_wdata <= mem.mem_data_i;
            we_q       <= mem.mem_we_i;
            cnt_q      <= DSRAM_CNT_W'(WAIT_CYCLES - 1);
        end else if (state_q == DSRAM_ACCESS) begin
            if (abort || last) begin
                sram_ce_n <= 1'b1;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b1;
                sram_be_n <= 4'hF;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (last && !we_q && !abort) rdata_q <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: behavioural async SRAM plus a queue of
// expected mem_data_o values pushed per request and popped at completion.
module tb_data_sram_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    data_sram_ctrl_if mem_if();

    data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mem_if),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Small SRAM model, word index aliased to the low 6 address bits.
    logic [31:0] sram_mem [0:63] = '{default: 32'h0};
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 32'h0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mem_if.mem_ce_i  = 1'b0;
        mem_if.mem_sel_i = 4'h0;
        mem_if.flush_i   = 1'b0;
    endtask

    // Drives one request and follows it to the DONE cycle; leaves the request
    // asserted so a caller can issue the next one in the IDLE cycle after DONE.
    task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd_exp, input int flush_cyc);
        int          stalls, strobe_lo, k;
        logic [3:0]  be_seen;
        logic [19:0] a_seen;
        logic [31:0] wd_seen;
        logic        err_seen;
        stalls = 0; strobe_lo = 0; be_seen = 4'hF; a_seen = '0; wd_seen = '0; err_seen = 1'b0;
        exp_q.push_back(we ? last_rd : rd_exp);
        if (!we) last_rd = rd_exp;
        @(posedge clk); #1;
        mem_if.mem_ce_i   = 1'b1;
        mem_if.mem_we_i   = we;
        mem_if.mem_sel_i  = sel;
        mem_if.mem_addr_i = addr;
        mem_if.mem_data_i = wd;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_if.mem_err_o) err_seen = 1'b1;
            if (!sram_ce_n) begin
                be_seen = sram_be_n; a_seen = sram_addr; wd_seen = sram_wdata;
            end
            if (!(we ? sram_we_n : sram_oe_n)) strobe_lo++;
            if (!mem_if.stall_o) break;
            stalls++;
            if (k == flush_cyc) mem_if.flush_i = 1'b1;
        end
        mem_if.flush_i = 1'b0;
        chk("done_seen", {31'h0, mem_if.stall_o}, 32'h0);
        chk("stall_cycles", stalls, W + 1);
        chk(we ? "we_low_cycles" : "oe_low_cycles", strobe_lo, W);
        chk("be_n", {28'h0, be_seen}, {28'h0, ~sel});
        chk("sram_addr", {12'h0, a_seen}, {12'h0, addr[21:2]});
        if (we) chk("sram_wdata", wd_seen, wd);
        chk("mem_err", {31'h0, err_seen}, 32'h0);
        chk("mem_data_o", mem_if.mem_data_o, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n             = 1'b0;
        mem_if.mem_ce_i   = 1'b1;
        mem_if.mem_we_i   = 1'b0;
        mem_if.mem_sel_i  = 4'hF;
        mem_if.mem_addr_i = 32'h8000_0104;
        mem_if.mem_data_i = 32'h0;
        mem_if.flush_i    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n",  {31'h0, sram_ce_n}, 32'h1);
        chk("rst_oe_n",  {31'h0, sram_oe_n}, 32'h1);
        chk("rst_we_n",  {31'h0, sram_we_n}, 32'h1);
        chk("rst_be_n",  {28'h0, sram_be_n}, 32'hF);
        chk("rst_stall", {31'h0, mem_if.stall_o}, 32'h0);
        chk("rst_data",  mem_if.mem_data_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_if.mem_ce_i = 1'b0; mem_if.mem_sel_i = 4'h0;

        access(1'b1, 4'hF, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0, -1); idle();
        access(1'b0, 4'hF, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, -1); idle();
        chk("read_addr_const", {12'h0, sram_addr}, 32'h0004_1);

        access(1'b1, 4'hF,    32'h8000_0200, 32'h1122_3344, 32'h0, -1); idle();
        access(1'b1, 4'b0100, 32'h8000_0200, 32'h5A5A_5A5A, 32'h0, -1);
        access(1'b0, 4'hF,    32'h8000_0200, 32'h0, 32'h115A_3344, -1); idle();

        // Null request: no stall, no SRAM cycle, read data untouched.
        exp_q.push_back(last_rd);
        @(posedge clk); #1;
        mem_if.mem_ce_i = 1'b1; mem_if.mem_sel_i = 4'h0; mem_if.mem_we_i = 1'b0;
        @(negedge clk);
        chk("null_stall", {31'h0, mem_if.stall_o}, 32'h0);
        @(negedge clk);
        chk("null_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("null_data", mem_if.mem_data_o, exp_q.pop_front());
        idle();

        // Flush during read ACCESS abandons the access.
        exp_q.push_back(last_rd);
        @(posedge clk); #1;
        mem_if.mem_ce_i = 1'b1; mem_if.mem_we_i = 1'b0; mem_if.mem_sel_i = 4'hF;
        mem_if.mem_addr_i = 32'h8000_0200;
        @(negedge clk);
        chk("fl_idle_stall", {31'h0, mem_if.stall_o}, 32'h1);
        @(negedge clk);
        chk("fl_access_oe_n", {31'h0, sram_oe_n}, 32'h0);
        mem_if.flush_i = 1'b1;
        @(negedge clk);
        chk("fl_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("fl_oe_n", {31'h0, sram_oe_n}, 32'h1);
        chk("fl_be_n", {28'h0, sram_be_n}, 32'hF);
        chk("fl_data", mem_if.mem_data_o, exp_q.pop_front());
        @(negedge clk);
        chk("fl_idle_ce_n", {31'h0, sram_ce_n}, 32'h1);
        idle();
        access(1'b0, 4'hF, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, -1); idle();

        // Flush during a write is ignored; the data must land.
        access(1'b1, 4'hF, 32'h8000_0308, 32'hCAFE_F00D, 32'h0, 1); idle();
        access(1'b0, 4'hF, 32'h8000_0308, 32'h0, 32'hCAFE_F00D, -1); idle();

`ifdef DSRAM_ADDR_CHECK_EN
        @(posedge clk); #1;
        mem_if.mem_ce_i = 1'b1; mem_if.mem_we_i = 1'b0; mem_if.mem_sel_i = 4'hF;
        mem_if.mem_addr_i = 32'h0000_1000;
        @(negedge clk);
        chk("aerr_err",   {31'h0, mem_if.mem_err_o}, 32'h1);
        chk("aerr_stall", {31'h0, mem_if.stall_o}, 32'h0);
        @(negedge clk);
        chk("aerr_ce_n",  {31'h0, sram_ce_n}, 32'h1);
        idle();
`endif

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
